// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage.
// Drives the register file write port and counts retired instructions.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_reg_write,
  input  logic [1:0]        in_wb_sel,
  input  logic [2:0]        in_load_type,
  input  logic [4:0]        in_write_reg,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_pc,
  output logic              RegWrite,
  output logic [4:0]        WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              wb_valid,
  output logic              load_misaligned,
  output logic [CNT_W-1:0]  instret
);

  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_LINK = 2'd2;

  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LHU = 3'd2;
  localparam logic [2:0] LT_LB  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;

  logic              valid;
  logic              regWr;
  logic [1:0]        wbSel;
  logic [2:0]        loadType;
  logic [4:0]        wrReg;
  logic [DATA_W-1:0] aluRes;
  logic [DATA_W-1:0] memData;
  logic [DATA_W-1:0] pc;

  // Halfword loads need even offsets, words need offset 0, bytes never fault.
  function automatic logic misal(
    input logic [2:0] lt,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    case (lt)
      LT_LH, LT_LHU: m = off[0];
      LT_LB, LT_LBU: m = 1'b0;
      default:       m = (off != 2'd0);
    endcase
    return m;
  endfunction

  logic inMisal;
  logic accept;

  assign inMisal = (in_wb_sel == SEL_LOAD)
                 & misal(in_load_type, in_alu_result[1:0]);
  assign accept  = in_valid & ~inMisal & ~flush & ~stall;

  // Stage register: reset, then flush bubble, then stall hold, else capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid    <= 1'b0;
      regWr    <= 1'b0;
      wbSel    <= '0;
      loadType <= '0;
      wrReg    <= '0;
      aluRes   <= '0;
      memData  <= '0;
      pc       <= '0;
    end else if (flush) begin
      valid    <= 1'b0;
      regWr    <= 1'b0;
    end else if (!stall) begin
      valid    <= in_valid;
      regWr    <= in_reg_write;
      wbSel    <= in_wb_sel;
      loadType <= in_load_type;
      wrReg    <= in_write_reg;
      aluRes   <= in_alu_result;
      memData  <= in_mem_data;
      pc       <= in_pc;
    end
  end

  // Retired-instruction counter, bumps on every accepted non-faulting entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      instret <= '0;
    end else if (accept) begin
      instret <= instret + 1'b1;
    end
  end

  logic [1:0]        off;
  logic [4:0]        byteShift;
  logic [DATA_W-1:0] shifted;
  logic [7:0]        selByte;
  logic [15:0]       selHalf;
  logic [DATA_W-1:0] loadData;

  assign off       = aluRes[1:0];
  assign byteShift = {~off, 3'b000};
  assign shifted   = memData >> byteShift;
  assign selByte   = shifted[7:0];
  assign selHalf   = off[1] ? memData[15:0] : memData[31:16];

  // Big-endian lane select with sign or zero extension.
  always_comb begin
    loadData = memData;
    case (loadType)
      LT_LH:   loadData = {{16{selHalf[15]}}, selHalf};
      LT_LHU:  loadData = {16'h0, selHalf};
      LT_LB:   loadData = {{24{selByte[7]}}, selByte};
      LT_LBU:  loadData = {24'h0, selByte};
      default: loadData = memData;
    endcase
  end

  // Writeback source mux; reserved select falls back to the ALU result.
  always_comb begin
    WriteData = aluRes;
    case (wbSel)
      SEL_LOAD: WriteData = loadData;
      SEL_LINK: WriteData = pc + 32'd8;
      default:  WriteData = aluRes;
    endcase
  end

  assign load_misaligned = valid & (wbSel == SEL_LOAD) & misal(loadType, off);
  assign wb_valid        = valid & ~load_misaligned;
  assign RegWrite        = wb_valid & regWr & (wrReg != 5'd0);
  assign WriteReg        = wrReg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed scoreboard bench for mem_wb_stage.
// Expected writeback results are queued at drive time and checked after capture.
module tb_mem_wb_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic        in_reg_write;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_load_type;
  logic [4:0]  in_write_reg;
  logic [31:0] in_alu_result;
  logic [31:0] in_mem_data;
  logic [31:0] in_pc;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        wb_valid;
  logic        load_misaligned;
  logic [31:0] instret;

  logic        rw2;
  logic [4:0]  wr2;
  logic [31:0] wd2;
  logic        wbv2;
  logic        mis2;
  logic [1:0]  cnt2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        wbv;
    logic        mis;
    logic [31:0] cnt;
    logic        chkData;
  } exp_t;

  exp_t sb[$];

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write),
    .in_wb_sel(in_wb_sel), .in_load_type(in_load_type),
    .in_write_reg(in_write_reg), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .in_pc(in_pc),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .wb_valid(wb_valid), .load_misaligned(load_misaligned),
    .instret(instret)
  );

  mem_wb_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write),
    .in_wb_sel(in_wb_sel), .in_load_type(in_load_type),
    .in_write_reg(in_write_reg), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .in_pc(in_pc),
    .RegWrite(rw2), .WriteReg(wr2), .WriteData(wd2),
    .wb_valid(wbv2), .load_misaligned(mis2),
    .instret(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic rw, input logic [4:0] wr,
                              input logic [31:0] wd, input logic wbv,
                              input logic mis, input logic [31:0] cnt,
                              input logic cd);
    exp_t e;
    e.rw = rw; e.wr = wr; e.wd = wd;
    e.wbv = wbv; e.mis = mis; e.cnt = cnt; e.chkData = cd;
    return e;
  endfunction

  task automatic step(input string tag,
                      input logic rs, input logic st, input logic fl,
                      input logic v, input logic rw,
                      input logic [1:0] sel, input logic [2:0] lt,
                      input logic [4:0] wr, input logic [31:0] alu,
                      input logic [31:0] mem, input logic [31:0] pc,
                      input exp_t e);
    exp_t g;
    reset = rs; stall = st; flush = fl;
    in_valid = v; in_reg_write = rw; in_wb_sel = sel;
    in_load_type = lt; in_write_reg = wr;
    in_alu_result = alu; in_mem_data = mem; in_pc = pc;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    checks++;
    assert (sb.size() > 0) else begin
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      g = sb.pop_front();
      chk({tag, "_RegWrite"}, {31'h0, RegWrite}, {31'h0, g.rw});
      chk({tag, "_wb_valid"}, {31'h0, wb_valid}, {31'h0, g.wbv});
      chk({tag, "_misal"}, {31'h0, load_misaligned}, {31'h0, g.mis});
      chk({tag, "_instret"}, instret, g.cnt);
      chk({tag, "_instret2"}, {30'h0, cnt2}, {30'h0, g.cnt[1:0]});
      if (g.chkData) begin
        chk({tag, "_WriteReg"}, {27'h0, WriteReg}, {27'h0, g.wr});
        chk({tag, "_WriteData"}, WriteData, g.wd);
      end
    end
  endtask

  localparam logic [31:0] MD = 32'h11F2337F;

  initial begin
    step("rst", 1, 0, 0, 1, 1, 0, 0, 8, 32'hDEAD, MD, 32'h40,
         mk(0, 0, 0, 0, 0, 0, 1));
    step("alu", 0, 0, 0, 1, 1, 0, 0, 8, 32'h12345678, MD, 0,
         mk(1, 8, 32'h12345678, 1, 0, 1, 1));
    step("lb1", 0, 0, 0, 1, 1, 1, 3, 9, 32'h1001, MD, 0,
         mk(1, 9, 32'hFFFFFFF2, 1, 0, 2, 1));
    step("lbu1", 0, 0, 0, 1, 1, 1, 4, 9, 32'h1001, MD, 0,
         mk(1, 9, 32'h000000F2, 1, 0, 3, 1));
    step("lh2", 0, 0, 0, 1, 1, 1, 1, 9, 32'h1002, MD, 0,
         mk(1, 9, 32'h0000337F, 1, 0, 4, 1));
    step("lhu0", 0, 0, 0, 1, 1, 1, 2, 9, 32'h1000, MD, 0,
         mk(1, 9, 32'h000011F2, 1, 0, 5, 1));
    step("lwmis", 0, 0, 0, 1, 1, 1, 0, 10, 32'h1002, MD, 0,
         mk(0, 10, MD, 0, 1, 5, 1));
    step("lhmis", 0, 0, 0, 1, 1, 1, 1, 10, 32'h1001, MD, 0,
         mk(0, 10, 32'h000011F2, 0, 1, 5, 1));
    step("link", 0, 0, 0, 1, 1, 2, 0, 31, 32'h5, MD, 32'h00400010,
         mk(1, 31, 32'h00400018, 1, 0, 6, 1));
    step("linkz", 0, 0, 0, 1, 1, 2, 0, 0, 32'h5, MD, 32'h00400010,
         mk(0, 0, 32'h00400018, 1, 0, 7, 1));
    step("linkwrap", 0, 0, 0, 1, 1, 2, 0, 5, 32'h5, MD, 32'hFFFFFFFC,
         mk(1, 5, 32'h00000004, 1, 0, 8, 1));
    step("lb3", 0, 0, 0, 1, 1, 1, 3, 6, 32'h1003, MD, 0,
         mk(1, 6, 32'h0000007F, 1, 0, 9, 1));
    step("lbu0", 0, 0, 0, 1, 1, 1, 4, 6, 32'h1000, MD, 0,
         mk(1, 6, 32'h00000011, 1, 0, 10, 1));
    step("lw0", 0, 0, 0, 1, 1, 1, 7, 7, 32'h1004, MD, 0,
         mk(1, 7, MD, 1, 0, 11, 1));
    step("entA", 0, 0, 0, 1, 1, 0, 0, 12, 32'hAAAA5555, MD, 0,
         mk(1, 12, 32'hAAAA5555, 1, 0, 12, 1));
    for (int i = 0; i < 3; i++) begin
      step("stall", 0, 1, 0, 1, 1, 0, 0, 13, 32'hBBBB0000, MD, 0,
           mk(1, 12, 32'hAAAA5555, 1, 0, 12, 1));
    end
    step("stfl", 0, 1, 1, 1, 1, 0, 0, 13, 32'hBBBB0000, MD, 0,
         mk(0, 0, 0, 0, 0, 12, 0));
    step("bubble", 0, 0, 0, 0, 1, 0, 0, 14, 32'h1, MD, 0,
         mk(0, 14, 32'h1, 0, 0, 12, 1));
    step("entC", 0, 0, 0, 1, 1, 0, 0, 14, 32'hC, MD, 0,
         mk(1, 14, 32'hC, 1, 0, 13, 1));
    step("midrst", 1, 1, 0, 1, 1, 0, 0, 15, 32'hF, MD, 0,
         mk(0, 0, 0, 0, 0, 0, 1));
    for (int i = 1; i <= 4; i++) begin
      step("wrap", 0, 0, 0, 1, 1, 0, 0, 3, 32'(i), MD, 0,
           mk(1, 3, 32'(i), 1, 0, 32'(i), 1));
    end
    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and writeback stage of the MIPS pipeline. Sits directly upstream of the register file and drives its write port (RegWrite, WriteReg, WriteData).
- Captures the memory-stage results each clock and selects the writeback source (ALU result, load data, or link address).
- Performs big-endian byte/halfword load extraction and sign/zero extension, suppresses writes to $zero and misaligned loads, and counts retired instructions.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold the stage register contents
- flush  input  1  replace the incoming entry with a bubble
- in_valid  input  1  MEM stage holds a real instruction
- in_reg_write  input  1  instruction writes a GPR
- in_wb_sel  input  2  writeback source: 0 ALU, 1 load, 2 link (PC+8), 3 reserved (treated as ALU)
- in_load_type  input  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5-7 treated as LW
- in_write_reg  input  5  destination register
- in_alu_result  input  32  ALU result; also the load address, low 2 bits give the byte offset
- in_mem_data  input  32  aligned word read from data memory
- in_pc  input  32  PC of the instruction
- RegWrite  output  1  register file write enable
- WriteReg  output  5  register file write address
- WriteData  output  32  register file write data
- wb_valid  output  1  stage holds a valid, non-faulting instruction
- load_misaligned  output  1  stage holds a load that is misaligned for its size
- instret  output  CNT_W  retired-instruction count

Behaviour:
- Stage register update, evaluated at every rising clk edge in this priority order:
  - reset: clear valid, reg_write, wb_sel, load_type, write_reg and all data fields to 0; clear instret to 0.
  - flush: clear valid and reg_write. Other fields are don't-care. Flush overrides stall.
  - stall: hold all fields and hold instret.
  - otherwise: capture all in_* signals.
- Outputs are combinational from the registered fields only; no input-to-output combinational path.
- Latency: an entry captured at edge N drives RegWrite/WriteData during cycle N→N+1, and the register file writes at edge N+1.
- Misalignment: a misaligned load is a LW with byte offset ≠ 0, or a LH/LHU with byte offset[0] = 1.
- load_misaligned = valid & (wb_sel == 1) & misaligned.
- wb_valid = valid & ~load_misaligned.
- RegWrite = wb_valid & reg_write & (write_reg ≠ 0). Writes to $zero are always suppressed.
- WriteReg = write_reg.
- WriteData:
  - wb_sel 0/3: alu_result.
  - wb_sel 2: pc + 8, with 32-bit wrap-around (0xFFFFFFFC → 0x00000004).
  - wb_sel 1: load-extracted data.
- Load extraction is big-endian. Byte offset 0 selects bits 31:24; offset 3 selects bits 7:0.
  - LB: sign-extend the selected byte. LBU: zero-extend it.
  - LH: sign-extend the halfword (offset 0 → bits 31:16, offset 2 → bits 15:0). LHU: zero-extend it.
  - LW: full word.
- While stalled, the held entry keeps RegWrite asserted; the repeated write of the same value is permitted.
- instret increments by 1, wrapping at 2^CNT_W − 1 → 0, at an edge where the incoming entry is accepted. Accepted means ~reset & ~flush & ~stall & in_valid, and the incoming instruction is not a misaligned load (evaluated on the in_* fields).
- After reset, RegWrite = 0, wb_valid = 0, load_misaligned = 0, WriteData = 0, instret = 0 until the first accepted entry.

Test Plan:
- Reset, then an ALU entry (in_valid=1, reg_write=1, wb_sel=0, write_reg=8, alu=0x12345678) → next cycle RegWrite=1, WriteReg=8, WriteData=0x12345678, instret=1.
- LB with mem_data=0x11F2337F: offset 1 → WriteData=0xFFFFFFF2; LBU offset 1 → 0x000000F2; LH offset 2 → 0x0000337F; LHU offset 0 → 0x000011F2.
- LW at alu=0x1002 → load_misaligned=1, RegWrite=0, wb_valid=0, instret unchanged; LH at offset 1 behaves the same.
- Link entry with in_pc=0x00400010, wb_sel=2, write_reg=31 → WriteData=0x00400018. Same entry with write_reg=0 → RegWrite=0.
- Capture entry A, then hold stall=1 for 3 cycles while presenting entry B → outputs stay A and instret is frozen. Then assert stall=1 and flush=1 together → bubble (RegWrite=0, wb_valid=0).
- Reset asserted mid-stream with a valid entry held → next cycle all outputs are 0 and instret=0. A counter preloaded to 0xFFFFFFFF wraps to 0 on the next accepted entry.
